// File: rtl/memory_dreq_ctrl_pkg.sv
// Shared memory-stage types: access arguments, data-bus handshake structs,
// the request FSM state type and the size-to-strobe helper.
package memory_dreq_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
    OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR
  } op_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic   valid;
    logic   write;
    msize_t msize;
    addr_t  addr;
    word_t  data;
  } memory_args_t;

  typedef struct packed {
    logic       valid;
    addr_t      addr;
    msize_t     size;
    logic [3:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  function automatic logic [3:0] msize_strobe(input msize_t s);
    case (s)
      MSIZE1:  return 4'b0001;
      MSIZE2:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Unaligned word ops always touch the whole aligned word on the bus.
  function automatic logic is_unaligned_op(input op_t o);
    return (o == OP_LWL) || (o == OP_LWR) || (o == OP_SWL) || (o == OP_SWR);
  endfunction

endpackage

// File: rtl/memory_dreq_ctrl_load_format.sv
// Combinational load-result formatter: byte/half extraction with sign or
// zero extension, and the LWL/LWR merge with the old rt value.
module memory_load_format
  import memory_dreq_ctrl_pkg::*;
(
  input  op_t        i_op,
  input  logic [1:0] i_off,
  input  word_t      i_m,
  input  word_t      i_rt,
  output word_t      o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_m[{i_off, 3'b000} +: 8];
  assign w_half = i_m[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_m;
    case (i_op)
      OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_data = {24'd0, w_byte};
      OP_LH:  o_data = {{16{w_half[15]}}, w_half};
      OP_LHU: o_data = {16'd0, w_half};
      // LWL: memory's low bytes land in the top of rt.
      OP_LWL: begin
        case (i_off)
          2'd0:    o_data = {i_m[7:0],  i_rt[23:0]};
          2'd1:    o_data = {i_m[15:0], i_rt[15:0]};
          2'd2:    o_data = {i_m[23:0], i_rt[7:0]};
          default: o_data = i_m;
        endcase
      end
      // LWR: memory's high bytes land in the bottom of rt.
      OP_LWR: begin
        case (i_off)
          2'd0:    o_data = i_m;
          2'd1:    o_data = {i_rt[31:24], i_m[31:8]};
          2'd2:    o_data = {i_rt[31:16], i_m[31:16]};
          default: o_data = {i_rt[31:8],  i_m[31:24]};
        endcase
      end
      default: o_data = i_m;
    endcase
  end

endmodule

// File: rtl/memory_dreq_ctrl.sv
// Data-bus request controller: issues dbus requests from the memory stage,
// holds them until addr_ok, waits for data_ok and presents the formatted result.
module memory_dreq_ctrl
  import memory_dreq_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  memory_args_t args,
  input  op_t          op,
  input  word_t        wdata,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  input  logic         advance,
  output logic         stall,
  output word_t        rdata,
  output logic         rdata_valid,
  output mem_state_t   dbg_state
);

  mem_state_t r_state;
  logic       r_req_valid;
  addr_t      r_addr;
  msize_t     r_size;
  logic [3:0] r_strobe;
  word_t      r_data;
  word_t      r_rdata;
  logic       r_rdata_valid;

  logic [1:0] w_off;
  logic [3:0] w_base;
  logic [3:0] w_strobe;
  addr_t      w_addr;
  msize_t     w_size;
  word_t      w_fmt;
  word_t      w_result;

  assign w_off  = args.addr[1:0];
  assign w_base = msize_strobe(args.msize);
  assign w_addr = is_unaligned_op(op) ? {args.addr[31:2], 2'b00} : args.addr;
  assign w_size = is_unaligned_op(op) ? MSIZE4 : args.msize;

  always_comb begin
    w_strobe = 4'b0000;
    case (op)
      OP_SB, OP_SH, OP_SW: w_strobe = w_base << w_off;
      OP_SWL:              w_strobe = 4'b1111 >> (2'd3 - w_off);
      OP_SWR:              w_strobe = 4'b1111 << w_off;
      default:             w_strobe = 4'b0000;
    endcase
  end

  // Operands stay stable while stalled, so formatting uses live inputs.
  memory_load_format u_load_format (
    .i_op   (op),
    .i_off  (w_off),
    .i_m    (dresp.data),
    .i_rt   (args.data),
    .o_data (w_fmt)
  );

  assign w_result = args.write ? '0 : w_fmt;

  always_comb begin
    dreq = '0;
    if (r_state == MEM_IDLE) begin
      dreq.valid  = args.valid;
      dreq.addr   = w_addr;
      dreq.size   = w_size;
      dreq.strobe = w_strobe;
      dreq.data   = wdata;
    end else begin
      dreq.valid  = r_req_valid;
      dreq.addr   = r_addr;
      dreq.size   = r_size;
      dreq.strobe = r_strobe;
      dreq.data   = r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= MEM_IDLE;
      r_req_valid   <= 1'b0;
      r_addr        <= '0;
      r_size        <= MSIZE1;
      r_strobe      <= '0;
      r_data        <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (args.valid) begin
            r_addr   <= w_addr;
            r_size   <= w_size;
            r_strobe <= w_strobe;
            r_data   <= wdata;
            if (dresp.addr_ok && dresp.data_ok) begin
              r_state       <= MEM_DONE;
              r_rdata       <= w_result;
              r_rdata_valid <= 1'b1;
            end else if (dresp.addr_ok) begin
              r_state <= MEM_WAIT;
            end else begin
              r_state     <= MEM_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        MEM_REQ: begin
          if (dresp.addr_ok) begin
            r_req_valid <= 1'b0;
            if (dresp.data_ok) begin
              r_state       <= MEM_DONE;
              r_rdata       <= w_result;
              r_rdata_valid <= 1'b1;
            end else begin
              r_state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dresp.data_ok) begin
            r_state       <= MEM_DONE;
            r_rdata       <= w_result;
            r_rdata_valid <= 1'b1;
          end
        end
        MEM_DONE: begin
          if (advance) begin
            r_state       <= MEM_IDLE;
            r_rdata_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign stall       = args.valid & (r_state != MEM_DONE);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_memory_dreq_ctrl.sv
// Directed bench for memory_dreq_ctrl: inputs change on the falling edge,
// outputs are checked at the falling edge or 1ns after an input change.
module tb_memory_dreq_ctrl;
  import memory_dreq_ctrl_pkg::*;

  logic         clk;
  logic         reset;
  memory_args_t args;
  op_t          op;
  word_t        wdata;
  dbus_req_t    dreq;
  dbus_resp_t   dresp;
  logic         advance;
  logic         stall;
  word_t        rdata;
  logic         rdata_valid;
  mem_state_t   dbg_state;

  int tests_run;
  int tests_failed;

  memory_dreq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .args        (args),
    .op          (op),
    .wdata       (wdata),
    .dreq        (dreq),
    .dresp       (dresp),
    .advance     (advance),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic issue(input op_t o, input msize_t s, input logic w,
                       input logic [31:0] a, input logic [31:0] rt, input logic [31:0] wd);
    args.valid = 1'b1;
    args.write = w;
    args.msize = s;
    args.addr  = a;
    args.data  = rt;
    op         = o;
    wdata      = wd;
  endtask

  task automatic set_resp(input logic aok, input logic dok, input logic [31:0] d);
    dresp.addr_ok = aok;
    dresp.data_ok = dok;
    dresp.data    = d;
  endtask

  // Called from DONE: hand off and confirm the FSM returns to IDLE.
  task automatic retire(input string tag);
    advance    = 1'b1;
    args.valid = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    check_eq({tag, ".idle"}, 32'(dbg_state), 32'(MEM_IDLE));
    check_eq({tag, ".rv_low"}, 32'(rdata_valid), 32'd0);
  endtask

  task automatic do_load(input string tag, input op_t o, input msize_t s,
                         input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] m, input logic [31:0] exp);
    @(negedge clk);
    issue(o, s, 1'b0, a, rt, 32'h0);
    set_resp(1'b1, 1'b1, m);
    #1;
    check_eq({tag, ".strobe"}, 32'(dreq.strobe), 32'd0);
    @(negedge clk);
    set_resp(1'b0, 1'b0, 32'h0);
    check_eq({tag, ".rdata"}, rdata, exp);
    check_eq({tag, ".rv"}, 32'(rdata_valid), 32'd1);
    retire(tag);
  endtask

  task automatic do_store(input string tag, input op_t o, input msize_t s,
                          input logic [31:0] a, input logic [3:0] exp_strobe,
                          input logic [31:0] exp_addr);
    @(negedge clk);
    issue(o, s, 1'b1, a, 32'h0, 32'hCAFEF00D);
    set_resp(1'b1, 1'b1, 32'hFFFFFFFF);
    #1;
    check_eq({tag, ".strobe"}, 32'(dreq.strobe), 32'(exp_strobe));
    check_eq({tag, ".addr"}, dreq.addr, exp_addr);
    @(negedge clk);
    set_resp(1'b0, 1'b0, 32'h0);
    check_eq({tag, ".rdata_zero"}, rdata, 32'h0);
    retire(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    args         = '0;
    op           = OP_NONE;
    wdata        = '0;
    dresp        = '0;
    advance      = 1'b0;
    reset        = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst.state", 32'(dbg_state), 32'(MEM_IDLE));
    check_eq("rst.dreq_valid", 32'(dreq.valid), 32'd0);
    check_eq("rst.rdata", rdata, 32'h0);
    check_eq("rst.rv", 32'(rdata_valid), 32'd0);
    check_eq("rst.stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // LW with addr_ok and data_ok in the issue cycle.
    @(negedge clk);
    issue(OP_LW, MSIZE4, 1'b0, 32'h80000004, 32'h0, 32'h0);
    set_resp(1'b1, 1'b1, 32'h11223344);
    #1;
    check_eq("lw.dreq_valid", 32'(dreq.valid), 32'd1);
    check_eq("lw.addr", dreq.addr, 32'h80000004);
    check_eq("lw.size", 32'(dreq.size), 32'(MSIZE4));
    check_eq("lw.stall_hi", 32'(stall), 32'd1);
    check_eq("lw.rv_lo", 32'(rdata_valid), 32'd0);
    @(negedge clk);
    set_resp(1'b0, 1'b0, 32'h0);
    check_eq("lw.rdata", rdata, 32'h11223344);
    check_eq("lw.rv", 32'(rdata_valid), 32'd1);
    check_eq("lw.stall_lo", 32'(stall), 32'd0);
    check_eq("lw.done_dreq", 32'(dreq.valid), 32'd0);
    retire("lw");

    // SB with addr_ok delayed three cycles; request fields must stay fixed.
    @(negedge clk);
    issue(OP_SB, MSIZE1, 1'b1, 32'h10000003, 32'h0, 32'hAB000000);
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("sb.c0.valid", 32'(dreq.valid), 32'd1);
    check_eq("sb.c0.strobe", 32'(dreq.strobe), 32'h8);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      wdata   = 32'h12345678;
      advance = 1'b1;
      if (c == 3) dresp.addr_ok = 1'b1;
      #1;
      check_eq($sformatf("sb.c%0d.state", c), 32'(dbg_state), 32'(MEM_REQ));
      check_eq($sformatf("sb.c%0d.valid", c), 32'(dreq.valid), 32'd1);
      check_eq($sformatf("sb.c%0d.strobe", c), 32'(dreq.strobe), 32'h8);
      check_eq($sformatf("sb.c%0d.addr", c), dreq.addr, 32'h10000003);
      check_eq($sformatf("sb.c%0d.data", c), dreq.data, 32'hAB000000);
      check_eq($sformatf("sb.c%0d.size", c), 32'(dreq.size), 32'(MSIZE1));
    end
    @(negedge clk);
    advance       = 1'b0;
    dresp.addr_ok = 1'b0;
    check_eq("sb.wait.state", 32'(dbg_state), 32'(MEM_WAIT));
    check_eq("sb.wait.valid", 32'(dreq.valid), 32'd0);
    check_eq("sb.wait.stall", 32'(stall), 32'd1);
    dresp.data_ok = 1'b1;
    #1;
    check_eq("sb.dok.stall", 32'(stall), 32'd1);
    @(negedge clk);
    dresp.data_ok = 1'b0;
    check_eq("sb.done.state", 32'(dbg_state), 32'(MEM_DONE));
    check_eq("sb.done.rv", 32'(rdata_valid), 32'd1);
    check_eq("sb.done.rdata", rdata, 32'h0);
    check_eq("sb.done.stall", 32'(stall), 32'd0);
    retire("sb");

    // Load formatting.
    do_load("lb",   OP_LB,  MSIZE1, 32'h00001002, 32'h0,        32'h00F00000, 32'hFFFFFFF0);
    do_load("lbu",  OP_LBU, MSIZE1, 32'h00001002, 32'h0,        32'h00F00000, 32'h000000F0);
    do_load("lhu",  OP_LHU, MSIZE2, 32'h00001002, 32'h0,        32'h80010000, 32'h00008001);
    do_load("lh",   OP_LH,  MSIZE2, 32'h00001000, 32'h0,        32'h12348001, 32'hFFFF8001);
    do_load("lwl1", OP_LWL, MSIZE4, 32'h00002001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344);
    do_load("lwr1", OP_LWR, MSIZE4, 32'h00002001, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC);
    do_load("lwl3", OP_LWL, MSIZE4, 32'h00002003, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
    do_load("lwr3", OP_LWR, MSIZE4, 32'h00002003, 32'h11223344, 32'hAABBCCDD, 32'h112233AA);

    // Store strobes and forced alignment.
    do_store("swr2", OP_SWR, MSIZE4, 32'h20000006, 4'b1100, 32'h20000004);
    do_store("swl0", OP_SWL, MSIZE4, 32'h20000008, 4'b0001, 32'h20000008);
    do_store("swl2", OP_SWL, MSIZE4, 32'h2000000A, 4'b0111, 32'h20000008);
    do_store("sh2",  OP_SH,  MSIZE2, 32'h20000012, 4'b1100, 32'h20000012);
    do_store("sw",   OP_SW,  MSIZE4, 32'h20000014, 4'b1111, 32'h20000014);

    // Reset while waiting for data_ok, then a stale data_ok.
    @(negedge clk);
    issue(OP_LW, MSIZE4, 1'b0, 32'h30000000, 32'h0, 32'h0);
    set_resp(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    set_resp(1'b0, 1'b0, 32'h0);
    check_eq("rstw.state", 32'(dbg_state), 32'(MEM_WAIT));
    reset      = 1'b1;
    args.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rstw.idle", 32'(dbg_state), 32'(MEM_IDLE));
    check_eq("rstw.dreq_valid", 32'(dreq.valid), 32'd0);
    check_eq("rstw.rv", 32'(rdata_valid), 32'd0);
    set_resp(1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    set_resp(1'b0, 1'b0, 32'h0);
    check_eq("late_dok.state", 32'(dbg_state), 32'(MEM_IDLE));
    check_eq("late_dok.rv", 32'(rdata_valid), 32'd0);
    check_eq("late_dok.rdata", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_dreq_ctrl.md
# memory_dreq_ctrl

Data-bus request controller directly downstream of the memory stage's store-data alignment logic. It takes the memory stage's access arguments and the byte-lane-aligned store word and drives the `dbus_req_t` handshake: strobe generation, request hold until `addr_ok`, and wait for `data_ok`. It also formats load results: sign/zero extension plus LWL/LWR merge. It holds `stall` high until the access completes, then presents the result until the pipeline advances.

## Interface
- No parameters. Widths are fixed by the shared types: `word_t` = 32, `addr_t` = 32.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `args` in `memory_args_t`: valid, write, msize, addr, data. For loads, `data` is the current rt value used for the LWL/LWR merge.
- `op` in `op_t`: instruction opcode; distinguishes LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR.
- `wdata` in `word_t`: lane-aligned store word from the upstream alignment block.
- `dreq` out `dbus_req_t`: valid, addr, size, strobe, data.
- `dresp` in `dbus_resp_t`: addr_ok, data_ok, data.
- `advance` in 1: memory stage hands its instruction to writeback this cycle.
- `stall` out 1: memory stage must hold.
- `rdata` out `word_t`: formatted load result; write-completion yields 0.
- `rdata_valid` out 1: `rdata` is valid and the access is complete.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - REQ: request issued, `addr_ok` not yet seen.
  - WAIT: address accepted, awaiting `data_ok`.
  - DONE: result held.
- IDLE: `dreq` is driven combinationally from the inputs when `args.valid`.
  - On `addr_ok` & `data_ok` in the same cycle → DONE.
  - On `addr_ok` alone → WAIT.
  - Otherwise → REQ.
  - `dreq.addr`, `size`, `strobe` and `data` are registered on the issuing cycle.
- REQ: keep `dreq.valid`=1 with the registered fields.
  - On `addr_ok` → WAIT, or → DONE if `data_ok` arrives in the same cycle.
- WAIT: `dreq.valid`=0. On `data_ok` → DONE, capturing the formatted `dresp.data` into the result register.
- DONE: `dreq.valid`=0 and `rdata_valid`=1. On `advance` → IDLE. A new access cannot issue in the DONE cycle, so there is a one-cycle gap.
- `stall` = `args.valid` & !(state==DONE). An access completing via `data_ok` this cycle still stalls; `stall` drops the next cycle.
- Strobe generation, with off = `addr[1:0]`:
  - SB: `4'b0001<<off`.
  - SH: `4'b0011<<off`.
  - SW: `1111`.
  - SWL: off 0/1/2/3 → `0001`/`0011`/`0111`/`1111`.
  - SWR: off 0/1/2/3 → `1111`/`1110`/`1100`/`1000`.
  - Loads: `0000`.
- Address and size:
  - LWL/LWR/SWL/SWR: `addr[1:0]` forced to `00`, size MSIZE4.
  - Others: `addr` passed unchanged, size = `msize`.
- Load format, with m = `dresp.data`:
  - LB/LBU: byte `m[8*off+:8]`, sign- or zero-extended.
  - LH/LHU: halfword `m[8*off+:16]`, off ∈ {0,2}.
  - LW: m.
  - LWL off k: upper (k+1) bytes come from m's low (k+1) bytes; lower (3-k) bytes keep rt.
  - LWR off k: lower (4-k) bytes come from m's upper (4-k) bytes; upper k bytes keep rt.
- Misaligned LH/LW/SH/SW never reach this block. Upstream clears `args.valid` on address error.

## Timing
- Reset values: state IDLE; `dreq.valid`=0; registered request fields 0; `rdata`=0; `rdata_valid`=0. `stall` follows its combinational equation from IDLE, so it equals `args.valid`.
- Minimum latency, with `addr_ok` & `data_ok` both arriving in the issue cycle: `rdata_valid` on cycle N+1.
- `addr_ok` without `dreq.valid` is ignored.
- `data_ok` in IDLE or DONE is ignored.
- `dreq` fields are stable from issue until `addr_ok`.
- `reset` mid-access: return to IDLE on the next edge and drop the outstanding request. The bus is reset simultaneously.
- `advance` outside DONE has no effect on the FSM.

## Structure
- `mem_state_t` (IDLE/REQ/WAIT/DONE) goes into the shared `mycpu` package header.
- Shared package helper function: `msize`→strobe base mask (`0001`/`0011`/`1111`).
- Natural sub-module: `memory_load_format`, a combinational block taking op, off, m and rt and producing the formatted word. It is reused by any future cached-load path.

## Test plan
- LW addr `0x80000004`, `addr_ok` & `data_ok` both in cycle 0, data `0x11223344` → `rdata`=`0x11223344`, `rdata_valid` in cycle 1, `stall` 1→0.
- SB addr `0x...03`, `wdata` `0xAB000000`, `addr_ok` delayed 3 cycles → `dreq.valid` held 4 cycles, strobe `1000`, fields constant; DONE after `data_ok`.
- LB off 2, m=`0x00F00000` → `0xFFFFFFF0`. LBU → `0x000000F0`. LHU off 2, m=`0x8001_0000` → `0x00008001`.
- LWL off 1, m=`0xAABBCCDD`, rt=`0x11223344` → `0xCCDD3344`. LWR off 1, same m and rt → `0x11AABBCC`.
- SWR off 2 → strobe `1100`, addr low bits `00`. SWL off 0 → strobe `0001`.
- Reset asserted in WAIT → next cycle IDLE, `dreq.valid`=0, `rdata_valid`=0. A following late `data_ok` is ignored.
